// File: rtl/led_pwm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : led_pwm_arbiter
// Brief   : Round-robin RGB LED owner arbitration with glitch-free PWM.
// Revision: 1.0
// ============================================================================
module led_pwm_arbiter #(
  parameter int PWM_BITS    = 8,
  parameter int HOLD_CYCLES = 48000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [3*PWM_BITS-1:0] colour_0,
  input  logic [3*PWM_BITS-1:0] colour_1,
  input  logic [3*PWM_BITS-1:0] colour_2,
  output logic [2:0]            grant,
  output logic                  busy,
  output logic                  pwm_red,
  output logic                  pwm_green,
  output logic                  pwm_blue
);

  localparam int                  c_HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] c_CNT_MAX  = '1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_OWN  = 1'b1;

  logic [0:0]            r_state;
  logic [2:0]            r_grant;
  logic [1:0]            r_last_owner;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [PWM_BITS-1:0]   r_duty_red;
  logic [PWM_BITS-1:0]   r_duty_green;
  logic [PWM_BITS-1:0]   r_duty_blue;
  logic                  r_pwm_red;
  logic                  r_pwm_green;
  logic                  r_pwm_blue;

  logic [1:0]            w_cand0;
  logic [1:0]            w_cand1;
  logic [1:0]            w_winner;
  logic [2:0]            w_winner_onehot;
  logic                  w_any_req;
  logic                  w_owner_req;
  logic                  w_other_req;
  logic                  w_hold_done;
  logic                  w_release;
  logic                  w_pwm_wrap;
  logic [3*PWM_BITS-1:0] w_colour;

  function automatic logic [1:0] f_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search order: last+1, last+2, last (mod 3).
  always_comb begin
    w_cand0  = f_next(r_last_owner);
    w_cand1  = f_next(w_cand0);
    w_winner = r_last_owner;
    if (req[w_cand0]) begin
      w_winner = w_cand0;
    end else if (req[w_cand1]) begin
      w_winner = w_cand1;
    end
  end

  assign w_winner_onehot = 3'b001 << w_winner;
  assign w_any_req       = |req;
  assign w_owner_req     = req[r_last_owner];
  assign w_other_req     = |(req & ~r_grant);
  assign w_hold_done     = (r_hold_cnt == c_HOLD_MAX);
  assign w_release       = w_hold_done && (!w_owner_req || w_other_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_grant      <= 3'b000;
      r_last_owner <= 2'd2;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            r_state      <= c_OWN;
            r_grant      <= w_winner_onehot;
            r_last_owner <= w_winner;
            r_hold_cnt   <= '0;
          end
        end
        c_OWN: begin
          if (w_release) begin
            r_state <= c_IDLE;
            r_grant <= 3'b000;
          end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_grant <= 3'b000;
        end
      endcase
    end
  end

  // Pre-edge grant selects the colour, so a same-edge grant change is not seen.
  always_comb begin
    w_colour = '0;
    case (r_grant)
      3'b001:  w_colour = colour_0;
      3'b010:  w_colour = colour_1;
      3'b100:  w_colour = colour_2;
      default: w_colour = '0;
    endcase
  end

  assign w_pwm_wrap = (r_pwm_cnt == c_CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt    <= '0;
      r_duty_red   <= '0;
      r_duty_green <= '0;
      r_duty_blue  <= '0;
      r_pwm_red    <= 1'b0;
      r_pwm_green  <= 1'b0;
      r_pwm_blue   <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
      r_pwm_red   <= (r_pwm_cnt < r_duty_red);
      r_pwm_green <= (r_pwm_cnt < r_duty_green);
      r_pwm_blue  <= (r_pwm_cnt < r_duty_blue);
      if (w_pwm_wrap) begin
        r_duty_red   <= w_colour[3*PWM_BITS-1:2*PWM_BITS];
        r_duty_green <= w_colour[2*PWM_BITS-1:PWM_BITS];
        r_duty_blue  <= w_colour[PWM_BITS-1:0];
      end
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state == c_OWN);
  assign pwm_red   = r_pwm_red;
  assign pwm_green = r_pwm_green;
  assign pwm_blue  = r_pwm_blue;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_pwm_arbiter
// Brief   : Self-checking bench for led_pwm_arbiter against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_led_pwm_arbiter;

  localparam int PB  = 4;
  localparam int HC  = 4;
  localparam int PER = 1 << PB;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req   = 3'b000;
  logic [11:0] colour_0 = '0;
  logic [11:0] colour_1 = '0;
  logic [11:0] colour_2 = '0;
  logic [2:0]  grant;
  logic        busy;
  logic        pwm_red;
  logic        pwm_green;
  logic        pwm_blue;

  led_pwm_arbiter #(.PWM_BITS(PB), .HOLD_CYCLES(HC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .colour_0 (colour_0),
    .colour_1 (colour_1),
    .colour_2 (colour_2),
    .grant    (grant),
    .busy     (busy),
    .pwm_red  (pwm_red),
    .pwm_green(pwm_green),
    .pwm_blue (pwm_blue)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: colour table [requester][channel r,g,b], owner -1 when unowned.
  int col [3][3];
  int m_owner, m_last, m_held, m_cnt;
  int m_duty [3];
  int m_pwm  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_colours();
    colour_0 = {4'(col[0][0]), 4'(col[0][1]), 4'(col[0][2])};
    colour_1 = {4'(col[1][0]), 4'(col[1][1]), 4'(col[1][2])};
    colour_2 = {4'(col[2][0]), 4'(col[2][1]), 4'(col[2][2])};
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_held  = 0;
    m_cnt   = 0;
    for (int c = 0; c < 3; c++) begin
      m_duty[c] = 0;
      m_pwm[c]  = 0;
    end
  endtask

  task automatic model_step();
    int  nxt [3];
    bit  others;
    for (int c = 0; c < 3; c++) nxt[c] = (m_cnt < m_duty[c]) ? 1 : 0;
    if (m_cnt == PER - 1)
      for (int c = 0; c < 3; c++) m_duty[c] = (m_owner < 0) ? 0 : col[m_owner][c];
    for (int c = 0; c < 3; c++) m_pwm[c] = nxt[c];
    m_cnt = (m_cnt + 1) % PER;
    if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int r;
        r = (m_last + k) % 3;
        if (m_owner < 0 && req[r]) begin
          m_owner = r;
          m_last  = r;
          m_held  = 0;
        end
      end
    end else begin
      others = (req & ~(3'b001 << m_owner)) != 3'b000;
      if (m_held >= HC - 1 && (!req[m_owner] || others)) m_owner = -1;
      else if (m_held < HC - 1) m_held++;
    end
  endtask

  function automatic logic [2:0] model_grant();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  task automatic compare_all();
    check("grant", 32'(grant), 32'(model_grant()));
    check("busy",  32'(busy),  32'(m_owner >= 0));
    check("pwm_red",   32'(pwm_red),   32'(m_pwm[0]));
    check("pwm_green", 32'(pwm_green), 32'(m_pwm[1]));
    check("pwm_blue",  32'(pwm_blue),  32'(m_pwm[2]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #13;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s_r, s_g, s_b;
    int pat, waits;
    logic [2:0] exp_g;

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) col[r][c] = $urandom_range(0, PER - 1);
    drive_colours();
    #1;
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_pwm",   32'({pwm_red, pwm_green, pwm_blue}), 32'd0);

    // All three requesting: 001,000,010,000,100,000 with 4-cycle phases.
    req = 3'b111;
    for (int i = 0; i < 45; i++) begin
      tick();
      pat = i % 15;
      if (pat < 4)       exp_g = 3'b001;
      else if (pat == 4) exp_g = 3'b000;
      else if (pat < 9)  exp_g = 3'b010;
      else if (pat == 9) exp_g = 3'b000;
      else if (pat < 14) exp_g = 3'b100;
      else               exp_g = 3'b000;
      check("rr_seq", 32'(grant), 32'(exp_g));
    end

    // One-cycle pulse in IDLE still yields a full hold.
    req = 3'b000;
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000;
    check("pulse_g0", 32'(grant), 32'b010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pulse_hold", 32'({grant, busy}), 32'b0101);
    end
    tick();
    check("pulse_end", 32'({grant, busy}), 32'b0000);

    // Duty count over one full period.
    do_reset();
    col[0][0] = 15; col[0][1] = 8; col[0][2] = 0;
    col[1][0] = 3;  col[1][1] = 12; col[1][2] = 6;
    drive_colours();
    req = 3'b001;
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!(m_cnt == 0 && m_duty[0] == 15) && waits < 40);
    check("duty_wait", 32'(waits < 40), 32'd1);
    s_r = 0; s_g = 0; s_b = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      s_r += int'(pwm_red);
      s_g += int'(pwm_green);
      s_b += int'(pwm_blue);
    end
    check("period_red",   32'(s_r), 32'd15);
    check("period_green", 32'(s_g), 32'd8);
    check("period_blue",  32'(s_b), 32'd0);

    // Owner handover mid-period.
    repeat (5) tick();
    req = 3'b010;
    repeat (60) tick();

    // Asynchronous reset while red is lit.
    req = 3'b001;
    waits = 0;
    while (!(pwm_red === 1'b1 && grant === 3'b001) && waits < 60) begin
      tick();
      waits++;
    end
    check("red_wait", 32'(waits < 60), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_pwm",   32'({pwm_red, pwm_green, pwm_blue}), 32'd0);
    model_reset();
    #15;
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b111;
    tick();
    check("arst_first", 32'(grant), 32'b001);

    // Quiet period: nothing lights.
    req = 3'b000;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      check("idle_out", 32'({grant, busy, pwm_red, pwm_green, pwm_blue}), 32'd0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        col[$urandom_range(0, 2)][$urandom_range(0, 2)] = $urandom_range(0, PER - 1);
        drive_colours();
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pwm_arbiter.md
Name: led_pwm_arbiter

Overview:
Shares the single RGB LED driver between three independent requesters, for example the two touch buttons and a heartbeat. Each requester supplies a 24-bit colour. The block grants exactly one requester at a time, round-robin, with a minimum hold time. It generates glitch-free per-channel PWM from the owner's colour. The pwm_* outputs drive the RGB driver's PWM inputs directly.

Parameters:
PWM_BITS, 8, PWM counter and duty width; period = 2^PWM_BITS clk cycles.
HOLD_CYCLES, 48000, minimum ownership in clk cycles (1 ms at 48 MHz); legal range ≥ 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  3  request bit per requester 0..2, level-sensitive
colour_0  input  3*PWM_BITS  requester 0 colour {red, green, blue}, red in the MSBs
colour_1  input  3*PWM_BITS  requester 1 colour, same packing
colour_2  input  3*PWM_BITS  requester 2 colour, same packing
grant  output  3  one-hot owner, 000 when unowned
busy  output  1  high while in OWN
pwm_red  output  1  red PWM
pwm_green  output  1  green PWM
pwm_blue  output  1  blue PWM

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low, clock port clk, reset port rst_n.
- On reset, all of these clear together:
  - grant = 000, busy = 0, pwm_* = 0.
  - All duty registers = 0, pwm_cnt = 0, hold_cnt = 0.
  - last_owner = 2, so requester 0 wins first.
  - State = IDLE.
- Reset mid-ownership drops grant immediately and blanks the LEDs.

FSM states:
- IDLE:
  - grant = 000.
  - If any req bit is high at edge N, grant is one-hot at edge N+1 (registered, 1-cycle latency).
  - Winner is chosen by searching last_owner+1, last_owner+2, last_owner (mod 3); first requester found wins.
  - On winning: last_owner ← winner, hold_cnt ← 0, go to OWN.
- OWN:
  - grant is held; hold_cnt increments, saturating at HOLD_CYCLES-1.
  - Release occurs when hold_cnt == HOLD_CYCLES-1 AND (req[owner] == 0 OR any other req bit == 1).
  - On release: go to IDLE with grant = 000 for exactly one cycle, then re-arbitrate.
  - Owner dropping req before hold expires does not shorten ownership.
  - A lone owner that keeps req high retains grant indefinitely.

PWM:
- pwm_cnt is free-running, PWM_BITS wide, wrapping from 2^PWM_BITS-1 to 0.
- Duty registers are loaded only on the cycle pwm_cnt == 2^PWM_BITS-1, so duty never changes mid-period:
  - from the granted requester's colour input, sampled live at that edge;
  - all zero if grant == 000 at that edge.
- pwm_x is registered: pwm_x ← (pwm_cnt < duty_x), compared before the counter increment.
- Duty 0 gives an output that is never high. Duty 2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
- Colour change is therefore visible at most 2^PWM_BITS+1 cycles after grant/colour changes.

Boundary conditions:
- Simultaneous requests from all three resolve per the round-robin order above; no requester is starved beyond 2 ownership periods.
- A req pulse shorter than one clk cycle in IDLE is lost.
- Grant changes and PWM wrap on the same edge: the duty load uses the grant value before that edge.

Test Plan (PWM_BITS=4, HOLD_CYCLES=4):
- Reset, then req=111 held → grant sequence 001, 000, 010, 000, 100, 000, 001…; each one-hot phase lasts exactly 4 cycles.
- req=010 pulsed for 1 cycle in IDLE → grant=010 for exactly 4 cycles, then 000; busy mirrors it.
- req=001, colour_0={4'hF,4'h8,4'h0} → after the next wrap, over each 16-cycle period red high 15, green high 8, blue high 0 cycles.
- Owner changes from 0 to 1 mid-period → pwm outputs keep 0's duty until pwm_cnt wraps, then show colour_1; no partial period.
- rst_n low asynchronously during OWN with pwm_red=1 → grant=000, busy=0, all pwm_*=0 before the next clk edge; after release, requester 0 wins first.
- No req for 40 cycles → grant=000; duties load 0 at wraps; all pwm_* stay 0.
